rr_lock_arbiter: RTL and testbench

- Parameterised round-robin arbiter with packet lock, for the router switch/output allocator.
- Rotating priority replaces fixed LSB-first priority, so no requester starves.
- A grant is held for the whole packet, from head flit to tail flit (wormhole), and released only when the tail flit advances.
- An optional watchdog breaks locks whose owner stops requesting.

---
 rtl/rr_lock_arbiter.sv | 158 +++++++++++++++
 tb/tb_rr_lock_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/rr_lock_arbiter.sv
// rtl/rr_lock_arbiter.sv - round-robin arbiter with wormhole packet lock (optional watchdog: RR_WATCHDOG_EN)
module rr_lock_arbiter #(
    parameter int NR     = 5,
    parameter int IDW    = (NR > 1) ? $clog2(NR) : 1,
    parameter int TO_CYC = 16
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic [NR-1:0]  REQ,
    input  logic           ADV,
    input  logic           TAIL,
    output logic [NR-1:0]  GRT,
    output logic [IDW-1:0] GRT_ID,
    output logic           LOCKED,
    output logic           ERR
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_LOCK = 1'b1
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] ptr_nxt;
    logic [IDW-1:0] owner;
    logic [IDW-1:0] owner_nxt;

    logic [NR-1:0]   grt;
    logic [IDW-1:0]  grt_id;
    logic            xfer;
    logic [2*NR-1:0] req_dbl;
    logic            found;
    int              idx;

    // Successor index with wrap; for NR=1 this is always 0.
    function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] i);
        if (int'(i) >= NR - 1) begin
            return '0;
        end
        return i + IDW'(1);
    endfunction

`ifdef RR_WATCHDOG_EN
    localparam int WDW = $clog2(TO_CYC + 1);
    logic [WDW-1:0] wd;
    logic [WDW-1:0] wd_nxt;
    logic           err_q;
    logic           err_nxt;
`endif

    // Zero-latency grant: owner-only while locked, rotating search from ptr while idle.
    always_comb begin
        grt     = '0;
        grt_id  = '0;
        found   = 1'b0;
        idx     = 0;
        req_dbl = {REQ, REQ};
        if (RST) begin
            grt    = '0;
            grt_id = '0;
        end else if (state == S_LOCK) begin
            if (REQ[owner]) begin
                grt[owner] = 1'b1;
                grt_id     = owner;
            end
        end else begin
            // The doubled vector lets the search run past NR-1 without a modulo.
            for (int k = 0; k < NR; k++) begin
                idx = int'(ptr) + k;
                if (!found && req_dbl[idx]) begin
                    found  = 1'b1;
                    grt_id = (idx >= NR) ? IDW'(idx - NR) : IDW'(idx);
                end
            end
            if (found) begin
                grt[grt_id] = 1'b1;
            end
        end
    end

    assign GRT    = grt;
    assign GRT_ID = grt_id;
    assign xfer   = (|grt) & ADV;
    assign LOCKED = (state == S_LOCK);

    // Next-state logic: lock on a non-tail head, release and rotate on the tail.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        owner_nxt = owner;
`ifdef RR_WATCHDOG_EN
        wd_nxt    = '0;
        err_nxt   = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (xfer) begin
                    if (TAIL) begin
                        ptr_nxt = next_idx(grt_id);
                    end else begin
                        state_nxt = S_LOCK;
                        owner_nxt = grt_id;
                    end
                end
            end
            S_LOCK: begin
                if (xfer) begin
                    if (TAIL) begin
                        state_nxt = S_IDLE;
                        ptr_nxt   = next_idx(owner);
                    end
`ifdef RR_WATCHDOG_EN
                end else if (wd == WDW'(TO_CYC - 1)) begin
                    // Owner has stalled too long: drop the lock and flag it.
                    state_nxt = S_IDLE;
                    ptr_nxt   = next_idx(owner);
                    err_nxt   = 1'b1;
                end else begin
                    wd_nxt = wd + WDW'(1);
`endif
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
            ptr   <= '0;
            owner <= '0;
`ifdef RR_WATCHDOG_EN
            wd    <= '0;
            err_q <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            owner <= owner_nxt;
`ifdef RR_WATCHDOG_EN
            wd    <= wd_nxt;
            err_q <= err_nxt;
`endif
        end
    end

`ifdef RR_WATCHDOG_EN
    assign ERR = err_q;
`else
    assign ERR = 1'b0;
`endif

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// tb/tb_rr_lock_arbiter.sv - directed and randomized check of rr_lock_arbiter against a packet-level model
module tb_rr_lock_arbiter;

    localparam int NR  = 5;
    localparam int IDW = 3;
    localparam int TO  = 4;

    logic           CLK = 1'b0;
    logic           RST = 1'b1;
    logic [NR-1:0]  REQ = '0;
    logic           ADV = 1'b0;
    logic           TAIL = 1'b0;
    logic [NR-1:0]  GRT;
    logic [IDW-1:0] GRT_ID;
    logic           LOCKED;
    logic           ERR;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: which requester owns the output, and where priority starts.
    int m_ptr  = 0;
    int m_own  = 0;
    int m_idle = 0;
    bit m_lock = 1'b0;
    bit m_err  = 1'b0;

    rr_lock_arbiter #(.NR(NR), .IDW(IDW), .TO_CYC(TO)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .REQ    (REQ),
        .ADV    (ADV),
        .TAIL   (TAIL),
        .GRT    (GRT),
        .GRT_ID (GRT_ID),
        .LOCKED (LOCKED),
        .ERR    (ERR)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One cycle: drive at negedge, compare with the model, then advance the model.
    task automatic step(input bit rst, input logic [NR-1:0] req, input bit adv, input bit tail);
        logic [NR-1:0] exp_grt;
        int            exp_id;
        bit            found;
        bit            xfer;
        int            c;
        @(negedge CLK);
        RST  = rst;
        REQ  = req;
        ADV  = adv;
        TAIL = tail;
        #1;
        exp_grt = '0;
        exp_id  = 0;
        found   = 1'b0;
        if (!rst) begin
            if (m_lock) begin
                if (req[m_own]) begin
                    exp_grt[m_own] = 1'b1;
                    exp_id         = m_own;
                end
            end else begin
                for (int k = 0; k < NR; k++) begin
                    c = (m_ptr + k) % NR;
                    if (!found && req[c]) begin
                        found       = 1'b1;
                        exp_id      = c;
                        exp_grt[c]  = 1'b1;
                    end
                end
            end
        end
        check("grt", GRT, exp_grt);
        check("grt_id", GRT_ID, exp_id);
        check("locked", LOCKED, m_lock);
        check("err", ERR, m_err);
        check("onehot0", $onehot0(GRT), 1);

        xfer  = (exp_grt != '0) && adv;
        m_err = 1'b0;
        if (rst) begin
            m_ptr  = 0;
            m_own  = 0;
            m_lock = 1'b0;
            m_idle = 0;
        end else if (!m_lock) begin
            if (xfer) begin
                if (tail) begin
                    m_ptr = (exp_id + 1) % NR;
                end else begin
                    m_lock = 1'b1;
                    m_own  = exp_id;
                    m_idle = 0;
                end
            end
        end else begin
            if (xfer) begin
                m_idle = 0;
                if (tail) begin
                    m_lock = 1'b0;
                    m_ptr  = (m_own + 1) % NR;
                end
            end else begin
`ifdef RR_WATCHDOG_EN
                m_idle++;
                if (m_idle == TO) begin
                    m_lock = 1'b0;
                    m_ptr  = (m_own + 1) % NR;
                    m_err  = 1'b1;
                    m_idle = 0;
                end
`endif
            end
        end
    endtask

    initial begin
        // Reset state
        step(1'b1, 5'b11111, 1'b1, 1'b1);
        step(1'b1, 5'b00000, 1'b0, 1'b0);

        // Rotation through all requesters and wrap to 0
        for (int k = 0; k < 6; k++) begin
            step(1'b0, 5'b11111, 1'b1, 1'b1);
            check("rot_id", GRT_ID, k % NR);
        end

        // Skip and wrap: complete a grant to 3 (ptr=4), then only 0 and 1 request
        step(1'b0, 5'b01000, 1'b1, 1'b1);
        check("skip_3", GRT_ID, 3);
        step(1'b0, 5'b00011, 1'b1, 1'b1);
        check("wrap_grt", GRT, 5'b00001);
        step(1'b0, 5'b00011, 1'b1, 1'b1);
        check("wrap_next", GRT_ID, 1);

        // Packet lock on 0 masks requester 2
        step(1'b1, 5'b00000, 1'b0, 1'b0);
        step(1'b0, 5'b00101, 1'b1, 1'b0);
        check("head0", GRT, 5'b00001);
        for (int k = 0; k < 2; k++) begin
            step(1'b0, 5'b00100, 1'b1, 1'b0);
            check("mask_grt", GRT, 5'b00000);
            check("mask_lock", LOCKED, 1);
        end
        step(1'b0, 5'b00101, 1'b1, 1'b1);
        check("tail0", GRT, 5'b00001);
        // Ptr now 1: requester 2 wins; its head locks the output
        step(1'b0, 5'b00101, 1'b1, 1'b0);
        check("after_unlock", GRT, 5'b00100);
        check("after_unlock_lk", LOCKED, 0);

        // Backpressure while locked on 2
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 5'b00111, 1'b0, 1'b0);
            check("bp_hold", GRT, 5'b00100);
        end
        step(1'b0, 5'b00111, 1'b1, 1'b1);
        step(1'b0, 5'b11111, 1'b0, 1'b0);
        check("bp_ptr3", GRT_ID, 3);

        // Reset mid-packet with owner 4
        step(1'b0, 5'b10000, 1'b1, 1'b0);
        step(1'b0, 5'b11111, 1'b0, 1'b0);
        check("lock4", GRT, 5'b10000);
        step(1'b1, 5'b11111, 1'b1, 1'b1);
        check("rst_grt", GRT, 5'b00000);
        step(1'b0, 5'b11111, 1'b0, 1'b0);
        check("rst_ptr0", GRT_ID, 0);
        check("rst_unlock", LOCKED, 0);

        // Lock on 1 then owner stops requesting
        step(1'b0, 5'b00010, 1'b1, 1'b0);
        for (int c = 1; c <= 6; c++) begin
            step(1'b0, 5'b00000, 1'b0, 1'b0);
`ifdef RR_WATCHDOG_EN
            check("wd_err", ERR, (c == 5) ? 1 : 0);
            check("wd_lock", LOCKED, (c <= 4) ? 1 : 0);
`else
            check("nowd_err", ERR, 0);
            check("nowd_lock", LOCKED, 1);
`endif
        end
`ifdef RR_WATCHDOG_EN
        step(1'b0, 5'b11111, 1'b0, 1'b0);
        check("wd_ptr2", GRT_ID, 2);
`endif

        // Randomized traffic
        step(1'b1, 5'b00000, 1'b0, 1'b0);
        for (int n = 0; n < 600; n++) begin
            step(($urandom_range(0, 59) == 0),
                 NR'($urandom),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 2) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
